hazard_controller: RTL and testbench

HAZARD_CONTROLLER -- requirements
Module: hazard_controller

---
 rtl/hazard_controller_if.sv | 53 +++++
 rtl/hazard_controller.sv | 160 ++++++++++++++++
 tb/tb_hazard_controller.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_controller_if.sv
// Hazard controller bundle: pipeline status in, stall/flush controls out.
interface hazard_controller_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       ID_Rs;
    logic [4:0]       ID_Rt;
    logic             ID_UsesRt;
    logic             EX_MemRead;
    logic             EX_RegWrite;
    logic [4:0]       EX_WriteRegister;
    logic             MEM_MemRead;
    logic             MEM_MemWrite;
    logic             MemReady;
    logic             Redirect;
    logic             CountClear;
    logic             PC_Write;
    logic             IF_ID_Enable;
    logic             ID_EX_Enable;
    logic             EX_MEM_Enable;
    logic             MEM_WB_Enable;
    logic             IF_ID_Flush;
    logic             ID_EX_Flush;
    logic             EX_MEM_Flush;
    logic             MEM_WB_Flush;
    logic             MEM_WriteInhibit;
    logic [1:0]       State;
    logic [CNT_W-1:0] StallCycles;
    logic [CNT_W-1:0] FlushEvents;

    modport master (
        output ID_Rs, ID_Rt, ID_UsesRt,
        output EX_MemRead, EX_RegWrite, EX_WriteRegister,
        output MEM_MemRead, MEM_MemWrite, MemReady,
        output Redirect, CountClear,
        input  PC_Write, IF_ID_Enable, ID_EX_Enable,
        input  EX_MEM_Enable, MEM_WB_Enable,
        input  IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush,
        input  MEM_WB_Flush, MEM_WriteInhibit,
        input  State, StallCycles, FlushEvents
    );

    modport slave (
        input  ID_Rs, ID_Rt, ID_UsesRt,
        input  EX_MemRead, EX_RegWrite, EX_WriteRegister,
        input  MEM_MemRead, MEM_MemWrite, MemReady,
        input  Redirect, CountClear,
        output PC_Write, IF_ID_Enable, ID_EX_Enable,
        output EX_MEM_Enable, MEM_WB_Enable,
        output IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush,
        output MEM_WB_Flush, MEM_WriteInhibit,
        output State, StallCycles, FlushEvents
    );
endinterface

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: startup flush, load-use, memory wait, redirect.
module hazard_controller #(
    parameter int START_CYCLES = 4,
    parameter int CNT_W        = 16
) (
    input logic                 clk,
    input logic                 reset,
    hazard_controller_if.slave  hif
);
    typedef enum logic [1:0] {
        INIT    = 2'd0,
        RUN     = 2'd1,
        MEMWAIT = 2'd2
    } state_t;

    localparam logic [3:0] INIT_LOAD = 4'(START_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic [3:0]       init_cnt_q, init_cnt_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;

    logic load_use, mem_busy;
    logic stall_inc, flush_inc;
    logic pc_write, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic if_id_fl, id_ex_fl, ex_mem_fl, mem_wb_fl;
    logic wr_inhibit;

    assign load_use = hif.EX_MemRead & hif.EX_RegWrite
                    & (hif.EX_WriteRegister != 5'd0)
                    & ((hif.EX_WriteRegister == hif.ID_Rs)
                       | (hif.ID_UsesRt
                          & (hif.EX_WriteRegister == hif.ID_Rt)));

    assign mem_busy = (hif.MEM_MemRead | hif.MEM_MemWrite)
                    & ~hif.MemReady;

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        stall_inc  = 1'b0;
        flush_inc  = 1'b0;
        pc_write   = 1'b1;
        if_id_en   = 1'b1;
        id_ex_en   = 1'b1;
        ex_mem_en  = 1'b1;
        mem_wb_en  = 1'b1;
        if_id_fl   = 1'b0;
        id_ex_fl   = 1'b0;
        ex_mem_fl  = 1'b0;
        mem_wb_fl  = 1'b0;
        wr_inhibit = 1'b0;
        unique case (state_q)
            INIT: begin
                pc_write   = 1'b0;
                if_id_fl   = 1'b1;
                id_ex_fl   = 1'b1;
                ex_mem_fl  = 1'b1;
                mem_wb_fl  = 1'b1;
                wr_inhibit = 1'b1;
                if (init_cnt_q == 4'd0) begin
                    state_d = RUN;
                end else begin
                    init_cnt_d = init_cnt_q - 4'd1;
                end
            end
            RUN: begin
                if (hif.Redirect) begin
                    if_id_fl   = 1'b1;
                    id_ex_fl   = 1'b1;
                    ex_mem_fl  = 1'b1;
                    mem_wb_fl  = 1'b1;
                    wr_inhibit = 1'b1;
                    flush_inc  = 1'b1;
                end else if (mem_busy) begin
                    pc_write  = 1'b0;
                    if_id_en  = 1'b0;
                    id_ex_en  = 1'b0;
                    ex_mem_en = 1'b0;
                    mem_wb_en = 1'b0;
                    stall_inc = 1'b1;
                    state_d   = MEMWAIT;
                end else if (load_use) begin
                    pc_write  = 1'b0;
                    if_id_en  = 1'b0;
                    id_ex_fl  = 1'b1;
                    stall_inc = 1'b1;
                end
            end
            MEMWAIT: begin
                // WB is frozen here, so Redirect cannot be a new event
                if (!hif.MemReady) begin
                    pc_write  = 1'b0;
                    if_id_en  = 1'b0;
                    id_ex_en  = 1'b0;
                    ex_mem_en = 1'b0;
                    mem_wb_en = 1'b0;
                    stall_inc = 1'b1;
                end else begin
                    state_d = RUN;
                    if (load_use) begin
                        pc_write  = 1'b0;
                        if_id_en  = 1'b0;
                        id_ex_fl  = 1'b1;
                        stall_inc = 1'b1;
                    end
                end
            end
            default: begin
                state_d    = INIT;
                init_cnt_d = INIT_LOAD;
            end
        endcase
    end

    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (hif.CountClear) begin
            stall_d = '0;
            flush_d = '0;
        end else begin
            if (stall_inc && stall_q != CNT_MAX) begin
                stall_d = stall_q + CNT_W'(1);
            end
            if (flush_inc && flush_q != CNT_MAX) begin
                flush_d = flush_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= INIT;
            init_cnt_q <= INIT_LOAD;
            stall_q    <= '0;
            flush_q    <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            stall_q    <= stall_d;
            flush_q    <= flush_d;
        end
    end

    assign hif.PC_Write         = pc_write;
    assign hif.IF_ID_Enable     = if_id_en;
    assign hif.ID_EX_Enable     = id_ex_en;
    assign hif.EX_MEM_Enable    = ex_mem_en;
    assign hif.MEM_WB_Enable    = mem_wb_en;
    assign hif.IF_ID_Flush      = if_id_fl;
    assign hif.ID_EX_Flush      = id_ex_fl;
    assign hif.EX_MEM_Flush     = ex_mem_fl;
    assign hif.MEM_WB_Flush     = mem_wb_fl;
    assign hif.MEM_WriteInhibit = wr_inhibit;
    assign hif.State            = state_q;
    assign hif.StallCycles      = stall_q;
    assign hif.FlushEvents      = flush_q;
endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: vector table plus multi-cycle sequences.
module tb_hazard_controller;
    localparam int CW = 4;

    localparam logic [9:0] O_IDLE = 10'b11111_0000_0;
    localparam logic [9:0] O_LU   = 10'b00111_0100_0;
    localparam logic [9:0] O_BUSY = 10'b00000_0000_0;
    localparam logic [9:0] O_RDR  = 10'b11111_1111_1;
    localparam logic [9:0] O_INIT = 10'b01111_1111_1;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    hazard_controller_if #(.CNT_W(CW)) hif ();

    hazard_controller #(.START_CYCLES(4), .CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .hif   (hif)
    );

    logic [9:0] o_vec;
    assign o_vec = {hif.PC_Write, hif.IF_ID_Enable, hif.ID_EX_Enable,
                    hif.EX_MEM_Enable, hif.MEM_WB_Enable,
                    hif.IF_ID_Flush, hif.ID_EX_Flush,
                    hif.EX_MEM_Flush, hif.MEM_WB_Flush,
                    hif.MEM_WriteInhibit};

    typedef struct {
        string      name;
        logic       redirect;
        logic       ex_mr;
        logic       ex_rw;
        logic [4:0] ex_wr;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic       mem_r;
        logic       mem_w;
        logic       ready;
        logic [9:0] exp;
    } vec_t;

    vec_t tbl [11];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        hif.ID_Rs            = 5'd0;
        hif.ID_Rt            = 5'd0;
        hif.ID_UsesRt        = 1'b0;
        hif.EX_MemRead       = 1'b0;
        hif.EX_RegWrite      = 1'b0;
        hif.EX_WriteRegister = 5'd0;
        hif.MEM_MemRead      = 1'b0;
        hif.MEM_MemWrite     = 1'b0;
        hif.MemReady         = 1'b0;
        hif.Redirect         = 1'b0;
        hif.CountClear       = 1'b0;
    endtask

    task automatic apply(input vec_t v);
        hif.Redirect         = v.redirect;
        hif.EX_MemRead       = v.ex_mr;
        hif.EX_RegWrite      = v.ex_rw;
        hif.EX_WriteRegister = v.ex_wr;
        hif.ID_Rs            = v.rs;
        hif.ID_Rt            = v.rt;
        hif.ID_UsesRt        = v.uses_rt;
        hif.MEM_MemRead      = v.mem_r;
        hif.MEM_MemWrite     = v.mem_w;
        hif.MemReady         = v.ready;
    endtask

    task automatic set_lu();
        hif.EX_MemRead       = 1'b1;
        hif.EX_RegWrite      = 1'b1;
        hif.EX_WriteRegister = 5'd8;
        hif.ID_Rs            = 5'd8;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        tbl[0]  = '{"idle",       0,0,0, 5'd0, 5'd0, 5'd0, 0,0,0,0, O_IDLE};
        tbl[1]  = '{"lu_rs",      0,1,1, 5'd8, 5'd8, 5'd0, 0,0,0,0, O_LU};
        tbl[2]  = '{"lu_r0",      0,1,1, 5'd0, 5'd0, 5'd0, 1,0,0,0, O_IDLE};
        tbl[3]  = '{"lu_rt",      0,1,1, 5'd9, 5'd3, 5'd9, 1,0,0,0, O_LU};
        tbl[4]  = '{"rt_unused",  0,1,1, 5'd9, 5'd3, 5'd9, 0,0,0,0, O_IDLE};
        tbl[5]  = '{"no_regwr",   0,1,0, 5'd8, 5'd8, 5'd0, 0,0,0,0, O_IDLE};
        tbl[6]  = '{"mem_busy",   0,0,0, 5'd0, 5'd0, 5'd0, 0,1,0,0, O_BUSY};
        tbl[7]  = '{"mem_ready",  0,0,0, 5'd0, 5'd0, 5'd0, 0,0,1,1, O_IDLE};
        tbl[8]  = '{"redirect",   1,0,0, 5'd0, 5'd0, 5'd0, 0,0,0,0, O_RDR};
        tbl[9]  = '{"rdr_all",    1,1,1, 5'd8, 5'd8, 5'd0, 0,0,1,0, O_RDR};
        tbl[10] = '{"busy_lu",    0,1,1, 5'd8, 5'd8, 5'd0, 0,1,0,0, O_BUSY};

        clear_in();
        reset = 1'b1;
        #1;
        chk("rst_state", 32'(hif.State), 32'd0);
        chk("rst_stall", 32'(hif.StallCycles), 32'd0);
        chk("rst_flush", 32'(hif.FlushEvents), 32'd0);
        chk("rst_outs", 32'(o_vec), 32'(O_INIT));
        step();
        step();
        reset = 1'b0;

        for (int i = 0; i < 4; i++) begin
            chk($sformatf("init_state%0d", i), 32'(hif.State), 32'd0);
            chk($sformatf("init_outs%0d", i), 32'(o_vec), 32'(O_INIT));
            step();
        end
        chk("run_entry", 32'(hif.State), 32'd1);
        chk("run_idle", 32'(o_vec), 32'(O_IDLE));

        for (int i = 0; i < 11; i++) begin
            apply(tbl[i]);
            #1;
            chk(tbl[i].name, 32'(o_vec), 32'(tbl[i].exp));
            chk({tbl[i].name, "_st"}, 32'(hif.State), 32'd1);
            clear_in();
            #1;
        end

        set_lu();
        #1;
        chk("lu_outs", 32'(o_vec), 32'(O_LU));
        step();
        clear_in();
        #1;
        chk("lu_stall", 32'(hif.StallCycles), 32'd1);
        chk("lu_state", 32'(hif.State), 32'd1);
        chk("lu_once", 32'(o_vec), 32'(O_IDLE));
        set_lu();
        hif.EX_WriteRegister = 5'd0;
        hif.ID_Rs            = 5'd0;
        step();
        clear_in();
        chk("r0_stall", 32'(hif.StallCycles), 32'd1);

        hif.CountClear = 1'b1;
        step();
        clear_in();
        chk("clr_stall", 32'(hif.StallCycles), 32'd0);

        hif.MEM_MemRead = 1'b1;
        #1;
        chk("mw_c1_outs", 32'(o_vec), 32'(O_BUSY));
        chk("mw_c1_st", 32'(hif.State), 32'd1);
        step();
        chk("mw_c2_outs", 32'(o_vec), 32'(O_BUSY));
        chk("mw_c2_st", 32'(hif.State), 32'd2);
        step();
        chk("mw_c3_outs", 32'(o_vec), 32'(O_BUSY));
        chk("mw_c3_st", 32'(hif.State), 32'd2);
        step();
        hif.MemReady = 1'b1;
        #1;
        chk("mw_c4_outs", 32'(o_vec), 32'(O_IDLE));
        chk("mw_c4_st", 32'(hif.State), 32'd2);
        step();
        clear_in();
        chk("mw_back", 32'(hif.State), 32'd1);
        chk("mw_stall", 32'(hif.StallCycles), 32'd3);

        hif.Redirect     = 1'b1;
        hif.MEM_MemWrite = 1'b1;
        set_lu();
        #1;
        chk("rdr_outs", 32'(o_vec), 32'(O_RDR));
        step();
        clear_in();
        chk("rdr_st", 32'(hif.State), 32'd1);
        chk("rdr_flushev", 32'(hif.FlushEvents), 32'd1);
        chk("rdr_nostall", 32'(hif.StallCycles), 32'd3);

        set_lu();
        for (int i = 0; i < (1 << CW) + 5; i++) step();
        chk("sat_stall", 32'(hif.StallCycles), 32'(4'hF));
        hif.CountClear = 1'b1;
        step();
        clear_in();
        chk("sat_clear", 32'(hif.StallCycles), 32'd0);
        chk("sat_clr_fe", 32'(hif.FlushEvents), 32'd0);

        hif.Redirect = 1'b1;
        step();
        clear_in();
        chk("fe_one", 32'(hif.FlushEvents), 32'd1);
        hif.MEM_MemRead = 1'b1;
        step();
        chk("rw_mw_st", 32'(hif.State), 32'd2);
        hif.Redirect = 1'b1;
        #1;
        chk("mw_rdr_ign", 32'(o_vec), 32'(O_BUSY));
        step();
        chk("mw_rdr_fe", 32'(hif.FlushEvents), 32'd1);
        chk("mw_stall2", 32'(hif.StallCycles), 32'd2);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_state", 32'(hif.State), 32'd0);
        chk("arst_stall", 32'(hif.StallCycles), 32'd0);
        chk("arst_fe", 32'(hif.FlushEvents), 32'd0);
        chk("arst_outs", 32'(o_vec), 32'(O_INIT));
        clear_in();
        step();
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
